// File: rtl/trojan_resp_checker.sv
// Exhaustive-vector response checker for single-output combinational DUTs.
// Sweeps all N_IN-bit vectors, captures responses and compares to GOLDEN.
module trojan_resp_checker #(
   parameter int                    N_IN   = 4,
   parameter int                    SETTLE = 1,
   parameter logic [(1<<N_IN)-1:0]  GOLDEN = '0
) (
   input  logic                   CK,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   dut_out,
   output logic [N_IN-1:0]        N,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          mismatch_cnt,
   output logic [N_IN-1:0]        first_fail_idx,
   output logic                   first_fail_vld,
   output logic [(1<<N_IN)-1:0]   resp_sig
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0]      CNT_END  = 4'(SETTLE - 1);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
   localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);

   logic [1:0]      state;
   logic [3:0]      cnt;
   logic [N_IN-1:0] vec;

   assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
   assign done = (state == S_DONE);
   assign pass = done && (mismatch_cnt == '0);

   // Drive the vector with its MSB on N[0].
   always_comb begin
      N = '0;
      for (int i = 0; i < N_IN; i++)
         N[i] = vec[N_IN-1-i];
   end

   // Sweep sequencer: settle, sample, compare, advance.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         vec            <= '0;
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
         first_fail_vld <= 1'b0;
         resp_sig       <= '0;
      end else if (abort) begin
         state <= S_IDLE;
         cnt   <= '0;
         vec   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state          <= S_SETTLE;
                  vec            <= '0;
                  cnt            <= '0;
                  mismatch_cnt   <= '0;
                  resp_sig       <= '0;
                  first_fail_vld <= 1'b0;
               end
            end
            S_SETTLE: begin
               cnt <= cnt + 4'd1;
               if (cnt == CNT_END)
                  state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               resp_sig[vec] <= dut_out;
               if (dut_out != GOLDEN[vec]) begin
                  mismatch_cnt <= mismatch_cnt + CNT_ONE;
                  if (!first_fail_vld) begin
                     first_fail_idx <= vec;
                     first_fail_vld <= 1'b1;
                  end
               end
               if (vec == VEC_LAST) begin
                  state <= S_DONE;
               end else begin
                  vec   <= vec + 1'b1;
                  cnt   <= '0;
                  state <= S_SETTLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trojan_resp_checker.sv
// Directed bench for trojan_resp_checker.
// Two instances: SETTLE=1 (a) and SETTLE=3 (b), both GOLDEN=16'hA5C3.
module tb_trojan_resp_checker;

   localparam logic [15:0] GOLD = 16'hA5C3;

   logic        CK = 1'b0;
   logic        reset = 1'b1;
   logic        start_a = 1'b0, abort_a = 1'b0;
   logic        start_b = 1'b0, abort_b = 1'b0;
   logic [15:0] mask = 16'h0000;

   logic        dut_out_a, dut_out_b;
   logic [3:0]  N_a, N_b;
   logic        busy_a, done_a, pass_a, ffv_a;
   logic        busy_b, done_b, pass_b, ffv_b;
   logic [4:0]  mc_a, mc_b;
   logic [3:0]  ffi_a, ffi_b;
   logic [15:0] rs_a, rs_b;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 CK = ~CK;

   function automatic logic [3:0] rev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   assign dut_out_a = GOLD[rev4(N_a)] ^ mask[rev4(N_a)];
   assign dut_out_b = GOLD[rev4(N_b)];

   trojan_resp_checker #(.N_IN(4), .SETTLE(1), .GOLDEN(GOLD)) u_a (
      .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
      .dut_out(dut_out_a), .N(N_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .mismatch_cnt(mc_a), .first_fail_idx(ffi_a),
      .first_fail_vld(ffv_a), .resp_sig(rs_a)
   );

   trojan_resp_checker #(.N_IN(4), .SETTLE(3), .GOLDEN(GOLD)) u_b (
      .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
      .dut_out(dut_out_b), .N(N_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .mismatch_cnt(mc_b), .first_fail_idx(ffi_b),
      .first_fail_vld(ffv_b), .resp_sig(rs_b)
   );

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   // Counts edges after the start edge until done rises (bounded).
   task automatic wait_done_a(input int from, output int cnt);
      cnt = from;
      while (!done_a && cnt < 300) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_N", N_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pass", pass_a, 0);
      chk("rst_mc", mc_a, 0);
      chk("rst_rs", rs_a, 0);
      chk("rst_ffv", ffv_a, 0);
      chk("rst_ffi", ffi_a, 0);
      reset = 1'b0;
      tick();
      chk("idle_busy", busy_a, 0);

      // 1: matching DUT
      mask = 16'h0000;
      pulse_a();
      chk("t1_busy", busy_a, 1);
      chk("t1_N0", N_a, 0);
      wait_done_a(0, n);
      chk("t1_lat", n, 32);
      chk("t1_pass", pass_a, 1);
      chk("t1_mc", mc_a, 0);
      chk("t1_rs", rs_a, 16'hA5C3);
      chk("t1_ffv", ffv_a, 0);
      chk("t1_N", N_a, 4'hF);

      // 2: vectors 5 and 12 inverted
      mask = 16'h1020;
      pulse_a();
      wait_done_a(0, n);
      chk("t2_lat", n, 32);
      chk("t2_mc", mc_a, 2);
      chk("t2_ffi", ffi_a, 5);
      chk("t2_ffv", ffv_a, 1);
      chk("t2_pass", pass_a, 0);
      chk("t2_rs", rs_a, 16'hB5E3);

      // 3: SETTLE=3, each vector held 4 cycles, MSB on N[0]
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 64; k++) begin
         chk("t3_N", N_b, rev4(4'(k / 4)));
         if (k == 63)
            chk("t3_done63", done_b, 0);
         tick();
      end
      chk("t3_done64", done_b, 1);
      chk("t3_Nlast", N_b, 4'hF);
      chk("t3_pass", pass_b, 1);
      chk("t3_rs", rs_b, 16'hA5C3);

      // 4: abort after 7 samples keeps partial results
      mask = 16'h1020;
      pulse_a();
      repeat (14) tick();
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("t4_busy", busy_a, 0);
      chk("t4_done", done_a, 0);
      chk("t4_N", N_a, 0);
      chk("t4_pass", pass_a, 0);
      chk("t4_mc", mc_a, 1);
      chk("t4_ffv", ffv_a, 1);
      chk("t4_ffi", ffi_a, 5);
      chk("t4_rs", rs_a, 16'h0063);
      tick();
      chk("t4_idle", busy_a, 0);
      mask = 16'h0000;
      pulse_a();
      chk("t4_clr_mc", mc_a, 0);
      chk("t4_clr_ffv", ffv_a, 0);
      chk("t4_clr_rs", rs_a, 0);
      wait_done_a(0, n);
      chk("t4_lat", n, 32);
      chk("t4_pass2", pass_a, 1);

      // 5: start mid-sweep ignored, start in DONE restarts
      mask = 16'h1020;
      pulse_a();
      repeat (9) tick();
      pulse_a();
      wait_done_a(10, n);
      chk("t5_lat", n, 32);
      chk("t5_mc", mc_a, 2);
      chk("t5_rs", rs_a, 16'hB5E3);
      pulse_a();
      chk("t5_done", done_a, 0);
      chk("t5_busy", busy_a, 1);
      chk("t5_mc0", mc_a, 0);
      chk("t5_ffv0", ffv_a, 0);
      chk("t5_rs0", rs_a, 0);
      chk("t5_N0", N_a, 0);

      // 6: async reset mid-SETTLE
      repeat (2) tick();
      chk("t6_busy_pre", busy_a, 1);
      chk("t6_rs_pre", rs_a, 16'h0001);
      #3;
      reset = 1'b1;
      #1;
      chk("t6_N", N_a, 0);
      chk("t6_busy", busy_a, 0);
      chk("t6_done", done_a, 0);
      chk("t6_pass", pass_a, 0);
      chk("t6_mc", mc_a, 0);
      chk("t6_rs", rs_a, 0);
      chk("t6_ffv", ffv_a, 0);
      chk("t6_ffi", ffi_a, 0);
      #2;
      reset = 1'b0;
      repeat (5) tick();
      chk("t6_idle_busy", busy_a, 0);
      chk("t6_idle_done", done_a, 0);
      chk("t6_idle_N", N_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trojan_resp_checker.md
Name: trojan_resp_checker

Overview:
- Synthesizable counterpart to the exhaustive-vector benches that drive our Benchmark_testing combinational DUTs.
- Generates every N_IN-bit input vector in ascending order, then samples the DUT's single-bit response for each one.
- Packs the responses into a signature and compares it bit-by-bit against a golden truth table.
- Reports pass/fail, mismatch count and first failing vector, for on-chip trojan screening.

Parameters:
N_IN, 4, DUT input width; vectors run 0 .. 2^N_IN-1.
SETTLE, 1, cycles from vector apply to sample; legal range 1..15.
GOLDEN, 16'h0000, expected truth table, width 2^N_IN; bit k = expected output for vector k.

Ports:
CK  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a sweep when idle or done.
abort  input  1  synchronous; returns to IDLE from any state.
dut_out  input  1  DUT output_single.
N  output  N_IN  vector driven to DUT; N[0] is MSB of the vector value.
busy  output  1  high in SETTLE/SAMPLE.
done  output  1  high in DONE.
pass  output  1  valid when done; 1 iff mismatch_cnt == 0.
mismatch_cnt  output  N_IN+1  count of vectors whose response differs from GOLDEN.
first_fail_idx  output  N_IN  lowest failing vector value.
first_fail_vld  output  1  set once first_fail_idx has been captured.
resp_sig  output  2^N_IN  captured responses; bit k = dut_out sampled for vector k.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - N, mismatch_cnt, first_fail_idx, resp_sig all 0.
  - busy, done, pass, first_fail_vld all 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start:
  - N <= 0, settle counter <= 0.
  - mismatch_cnt, resp_sig, first_fail_vld cleared.
  - done and pass drop, state SETTLE.
  - In the same cycle, abort has priority over start.
- SETTLE: counter increments each cycle; when counter == SETTLE-1, next state SAMPLE.
- SAMPLE (exactly one cycle):
  - resp_sig[N] <= dut_out.
  - If dut_out != GOLDEN[N]: mismatch_cnt +1. If first_fail_vld is 0, also first_fail_idx <= N and first_fail_vld <= 1.
  - If N == 2^N_IN-1, next state DONE.
  - Otherwise N <= N+1, counter <= 0, next state SETTLE.
- Timing per vector: SETTLE+1 cycles. Full sweep takes 2^N_IN*(SETTLE+1) cycles from the start edge to the done rise.
- DONE:
  - done = 1, pass = (mismatch_cnt == 0).
  - N holds the last vector; all results hold until the next start or abort.
- start while busy: ignored, with no restart and no counter change.
- abort: next state IDLE; busy, done and pass go to 0; N <= 0. mismatch_cnt, resp_sig and first_fail_* keep their partial values for debug.
- Saturation:
  - mismatch_cnt cannot overflow; its maximum is 2^N_IN, which fits in N_IN+1 bits.
  - N wraps only through the DONE transition, never by incrementing past 2^N_IN-1.
- Reset mid-sweep: immediate return to reset values; no partial-result retention.
- dut_out is sampled only in SAMPLE; glitches during SETTLE have no effect.

Test Plan:
1. GOLDEN=16'hA5C3, SETTLE=1, DUT model returns GOLDEN[N], one start pulse -> done rises 32 cycles after start; pass=1, mismatch_cnt=0, resp_sig=16'hA5C3, first_fail_vld=0.
2. Same GOLDEN; model inverts responses for vectors 5 and 12 -> mismatch_cnt=2, first_fail_idx=5, first_fail_vld=1, pass=0, resp_sig=16'hA5C3^16'h1020.
3. SETTLE=3, matching DUT; probe N -> each vector held 4 cycles; done rises 64 cycles after start; N=15 while in DONE.
4. Assert abort after 7 samples -> IDLE next cycle, busy=0, done=0, N=0. A new start clears the results; the full sweep then passes.
5. start pulsed mid-sweep, then a second start in DONE -> first is ignored, timing unchanged. Second restarts with counters cleared and done low the next cycle.
6. reset asserted asynchronously mid-SETTLE, away from the CK edge -> all outputs go to 0 immediately. After release the block stays in IDLE until start.
